// File: rtl/song_transport_ctrl.sv
// song_transport_ctrl: transport sequencer for the tone generator.
// Fetches note bytes from the note store, decodes them, and times each
// note or rest against a tempo-scaled beat tick. It drives a registered
// {octave, note} code plus a mute flag.
// Optional build macro: SONG_LOOP_EN. When it is defined, the end-of-song
// byte restarts playback at the latched song base address. When it is
// undefined, the end-of-song byte returns the controller to IDLE.
module song_transport_ctrl #(
    parameter logic [15:0] TICK_BASE = 16'd50000,
    parameter int          ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic [ADDR_W-1:0] song_base,
    input  logic [3:0]        tempo,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    output logic [6:0]        freq_out,
    output logic              mute,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_HOLD,
        S_PAUSED
    } state_t;

    state_t            state;
    logic [2:0]        octave;
    logic [ADDR_W-1:0] base_lat;
    logic [7:0]        note_byte;
    logic [4:0]        beat_cnt;
    logic [15:0]       presc;
    logic [3:0]        div;
    logic              mute_saved;

    logic [3:0] code;
    logic [3:0] arg;
    logic [3:0] beat_limit;
    logic       sub_tick;
    logic       beat_tick;
    logic       note_end;

    // Timing strobes derived from the HOLD counters. Tempo is compared live,
    // and >= keeps the divider wrapping if tempo is raised mid-beat.
    always_comb begin
        code       = note_byte[7:4];
        arg        = note_byte[3:0];
        beat_limit = 4'd15 - tempo;
        sub_tick   = (presc == (TICK_BASE - 16'd1));
        beat_tick  = sub_tick && (div >= beat_limit);
        note_end   = beat_tick && (beat_cnt <= 5'd1);
    end

    // Transport state machine with all outputs registered. Stop has the
    // highest priority and abandons any outstanding fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            octave     <= 3'd0;
            base_lat   <= '0;
            note_byte  <= 8'd0;
            beat_cnt   <= 5'd0;
            presc      <= 16'd0;
            div        <= 4'd0;
            mute_saved <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            freq_out   <= 7'd0;
            mute       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state  <= S_IDLE;
                rd_req <= 1'b0;
                mute   <= 1'b1;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (play) begin
                            rd_addr  <= song_base;
                            base_lat <= song_base;
                            octave   <= 3'd0;
                            rd_req   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (rd_valid) begin
                            note_byte <= rd_data;
                            rd_req    <= 1'b0;
                            state     <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (code <= 4'd11) begin
                            freq_out <= {octave, code};
                            mute     <= 1'b0;
                            beat_cnt <= {1'b0, arg} + 5'd1;
                            presc    <= 16'd0;
                            div      <= 4'd0;
                            state    <= S_HOLD;
                        end else begin
                            case (code)
                                4'd12: begin
                                    if (arg < 4'd5) begin
                                        octave <= arg[2:0];
                                    end
                                    rd_addr <= rd_addr + 1'b1;
                                    rd_req  <= 1'b1;
                                    state   <= S_FETCH;
                                end
                                4'd13: begin
                                    rd_addr <= rd_addr + 1'b1;
                                    rd_req  <= 1'b1;
                                    state   <= S_FETCH;
                                end
                                4'd14: begin
                                    mute     <= 1'b1;
                                    beat_cnt <= {1'b0, arg} + 5'd1;
                                    presc    <= 16'd0;
                                    div      <= 4'd0;
                                    state    <= S_HOLD;
                                end
                                default: begin
`ifdef SONG_LOOP_EN
                                    rd_addr <= base_lat;
                                    rd_req  <= 1'b1;
                                    done    <= 1'b1;
                                    state   <= S_FETCH;
`else
                                    done    <= 1'b1;
                                    mute    <= 1'b1;
                                    busy    <= 1'b0;
                                    state   <= S_IDLE;
`endif
                                end
                            endcase
                        end
                    end
                    S_HOLD: begin
                        if (note_end) begin
                            beat_cnt <= 5'd0;
                            presc    <= 16'd0;
                            div      <= 4'd0;
                            rd_addr  <= rd_addr + 1'b1;
                            rd_req   <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            if (sub_tick) begin
                                presc <= 16'd0;
                                if (beat_tick) begin
                                    div      <= 4'd0;
                                    beat_cnt <= beat_cnt - 5'd1;
                                end else begin
                                    div <= div + 4'd1;
                                end
                            end else begin
                                presc <= presc + 16'd1;
                            end
                            if (pause) begin
                                mute_saved <= mute;
                                mute       <= 1'b1;
                                state      <= S_PAUSED;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (play) begin
                            mute  <= mute_saved;
                            state <= S_HOLD;
                        end
                    end
                    default: begin
                        rd_req <= 1'b0;
                        busy   <= 1'b0;
                        mute   <= 1'b1;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_transport_ctrl.sv
// tb_song_transport_ctrl: scoreboard bench for song_transport_ctrl.
// Expected fetch addresses and note records are queued as each scenario is
// set up. A monitor pops and compares them as the DUT fetches and plays.
module tb_song_transport_ctrl;

    localparam logic [15:0] TB_TICK = 16'd4;

    typedef struct packed {
        logic [6:0]  freq;
        logic        mute;
        logic [15:0] dur;
    } note_exp_t;

    logic       clk;
    logic       rst;
    logic       play;
    logic       pause;
    logic       stop;
    logic [7:0] song_base;
    logic [3:0] tempo;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [6:0] freq_out;
    logic       mute;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:255];
    logic       stall;
    logic       late_valid;
    logic [7:0] late_data;
    logic       seen;

    logic [7:0] addr_q [$];
    note_exp_t  note_q [$];

    int         errors;
    int         checks;
    int         done_cnt;
    int         run;
    logic       prev_req;
    logic [6:0] cap_freq;
    logic       cap_mute;

    song_transport_ctrl #(
        .TICK_BASE (TB_TICK),
        .ADDR_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
        .song_base (song_base),
        .tempo     (tempo),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .freq_out  (freq_out),
        .mute      (mute),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Note store model with one cycle of rd_valid latency, or forced stall
    always @(negedge clk) begin
        if (stall) begin
            seen     = 1'b0;
            rd_valid = late_valid;
            rd_data  = late_data;
        end else if (rd_valid) begin
            rd_valid = 1'b0;
            seen     = 1'b0;
        end else if (rd_req) begin
            if (seen) begin
                rd_valid = 1'b1;
                rd_data  = mem[rd_addr];
                seen     = 1'b0;
            end else begin
                seen = 1'b1;
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Scoreboard monitor: fetch addresses on rd_req rise, note records when
    // a busy-but-not-fetching run ends (first cycle of a run is DECODE)
    always @(negedge clk) begin
        logic [7:0] exp_a;
        note_exp_t  exp_n;
        if (rst) begin
            run      = 0;
            prev_req = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (rd_req && !prev_req) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL fetch_addr got unexpected fetch at %h, none queued", rd_addr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (rd_addr !== exp_a) begin
                        errors++;
                        $display("[TB] FAIL fetch_addr got %h expected %h", rd_addr, exp_a);
                    end
                end
            end
            prev_req = rd_req;
            if (busy && !rd_req) begin
                run++;
                if (run == 2) begin
                    cap_freq = freq_out;
                    cap_mute = mute;
                end
            end else begin
                if (run >= 2) begin
                    checks++;
                    if (note_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL note_rec got unexpected note of %0d cycles", run - 1);
                    end else begin
                        exp_n = note_q.pop_front();
                        if (cap_freq !== exp_n.freq) begin
                            errors++;
                            $display("[TB] FAIL note_freq got %h expected %h", cap_freq, exp_n.freq);
                        end
                        checks++;
                        if (cap_mute !== exp_n.mute) begin
                            errors++;
                            $display("[TB] FAIL note_mute got %b expected %b", cap_mute, exp_n.mute);
                        end
                        checks++;
                        if ((run - 1) != int'(exp_n.dur)) begin
                            errors++;
                            $display("[TB] FAIL note_dur got %0d expected %0d", run - 1, exp_n.dur);
                        end
                    end
                end
                run = 0;
            end
        end
    end

    // Advance to just after the next falling edge
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        next_cycle();
        play = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        checks++; if (rd_req !== 1'b0)   begin errors++; $display("[TB] FAIL reset_rd_req got %b expected 0", rd_req); end
        checks++; if (rd_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_addr got %h expected 00", rd_addr); end
        checks++; if (freq_out !== 7'h00) begin errors++; $display("[TB] FAIL reset_freq got %h expected 00", freq_out); end
        checks++; if (mute !== 1'b1)     begin errors++; $display("[TB] FAIL reset_mute got %b expected 1", mute); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_note_timing();
        int start;
        mem[8'h00] = 8'hC3;
        mem[8'h01] = 8'h52;
        mem[8'h02] = 8'hF0;
        tempo     = 4'd15;
        song_base = 8'h00;
        addr_q.push_back(8'h00);
        addr_q.push_back(8'h01);
        addr_q.push_back(8'h02);
        note_q.push_back('{freq: 7'h35, mute: 1'b0, dur: 16'd12});
        start = done_cnt;
        pulse_play();
        for (int i = 0; i < 200 && done_cnt == start; i++) next_cycle();
        checks++;
        if (done_cnt != start + 1) begin
            errors++;
            $display("[TB] FAIL timing_done got %0d pulses expected 1", done_cnt - start);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timing_idle_at_done got busy=%b expected 0", busy); end
        checks++; if (mute !== 1'b1) begin errors++; $display("[TB] FAIL timing_mute_end got %b expected 1", mute); end
        checks++; if (freq_out !== 7'h35) begin errors++; $display("[TB] FAIL timing_freq_held got %h expected 35", freq_out); end
        next_cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL timing_done_width got %b expected 0", done); end
        checks++;
        if (addr_q.size() != 0 || note_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL timing_drain got %0d/%0d left expected 0/0", addr_q.size(), note_q.size());
        end
    endtask

    task automatic test_rest_tempo();
        int start;
        mem[8'h10] = 8'hE1;
        mem[8'h11] = 8'hF0;
        tempo     = 4'd14;
        song_base = 8'h10;
        addr_q.push_back(8'h10);
        addr_q.push_back(8'h11);
        note_q.push_back('{freq: 7'h35, mute: 1'b1, dur: 16'd16});
        start = done_cnt;
        pulse_play();
        for (int i = 0; i < 200 && done_cnt == start; i++) next_cycle();
        checks++;
        if (done_cnt != start + 1) begin
            errors++;
            $display("[TB] FAIL rest_done got %0d pulses expected 1", done_cnt - start);
        end
        next_cycle();
        checks++;
        if (addr_q.size() != 0 || note_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rest_drain got %0d/%0d left expected 0/0", addr_q.size(), note_q.size());
        end
    endtask

    task automatic test_pause_resume();
        int start;
        mem[8'h20] = 8'h73;
        mem[8'h21] = 8'hF0;
        tempo     = 4'd15;
        song_base = 8'h20;
        addr_q.push_back(8'h20);
        addr_q.push_back(8'h21);
        note_q.push_back('{freq: 7'h07, mute: 1'b0, dur: 16'd37});
        start = done_cnt;
        pulse_play();
        for (int i = 0; i < 50 && rd_req; i++) next_cycle();
        next_cycle();
        repeat (5) next_cycle();
        pause = 1'b1;
        next_cycle();
        pause = 1'b0;
        checks++; if (mute !== 1'b1) begin errors++; $display("[TB] FAIL pause_mute got %b expected 1", mute); end
        repeat (19) next_cycle();
        checks++; if (busy !== 1'b1 || rd_req !== 1'b0) begin errors++; $display("[TB] FAIL pause_frozen got busy=%b rd_req=%b expected 1/0", busy, rd_req); end
        next_cycle();
        pulse_play();
        checks++; if (mute !== 1'b0) begin errors++; $display("[TB] FAIL resume_mute got %b expected 0", mute); end
        for (int i = 0; i < 200 && done_cnt == start; i++) next_cycle();
        checks++;
        if (done_cnt != start + 1) begin
            errors++;
            $display("[TB] FAIL pause_done got %0d pulses expected 1", done_cnt - start);
        end
        next_cycle();
        checks++;
        if (addr_q.size() != 0 || note_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pause_drain got %0d/%0d left expected 0/0", addr_q.size(), note_q.size());
        end
    endtask

    task automatic test_stop_fetch(input logic [6:0] held_freq);
        stall      = 1'b1;
        late_valid = 1'b0;
        late_data  = 8'h52;
        song_base  = 8'h30;
        addr_q.push_back(8'h30);
        pulse_play();
        next_cycle();
        next_cycle();
        checks++; if (rd_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_rd_req got %b expected 1", rd_req); end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        checks++; if (rd_req !== 1'b0) begin errors++; $display("[TB] FAIL stop_rd_req got %b expected 0", rd_req); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL stop_busy got %b expected 0", busy); end
        checks++; if (mute !== 1'b1)   begin errors++; $display("[TB] FAIL stop_mute got %b expected 1", mute); end
        late_valid = 1'b1;
        next_cycle();
        next_cycle();
        late_valid = 1'b0;
        next_cycle();
        checks++; if (rd_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL late_valid got rd_req=%b busy=%b expected 0/0", rd_req, busy); end
        checks++; if (freq_out !== held_freq) begin errors++; $display("[TB] FAIL stop_freq_held got %h expected %h", freq_out, held_freq); end
        addr_q.push_back(8'h30);
        pulse_play();
        checks++; if (rd_req !== 1'b1) begin errors++; $display("[TB] FAIL refetch_rd_req got %b expected 1", rd_req); end
        rst = 1'b1;
        #1;
        checks++; if (rd_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset got rd_req=%b busy=%b expected 0/0", rd_req, busy); end
        next_cycle();
        rst   = 1'b0;
        stall = 1'b0;
        next_cycle();
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stop_drain got %0d left expected 0", addr_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        int start;
        mem[8'hFF] = 8'h01;
        tempo     = 4'd15;
        song_base = 8'hFF;
        addr_q.push_back(8'hFF);
        addr_q.push_back(8'h00);
        addr_q.push_back(8'h01);
        addr_q.push_back(8'h02);
        note_q.push_back('{freq: 7'h00, mute: 1'b0, dur: 16'd8});
        note_q.push_back('{freq: 7'h35, mute: 1'b0, dur: 16'd12});
        start = done_cnt;
        pulse_play();
        for (int i = 0; i < 300 && done_cnt == start; i++) next_cycle();
        checks++;
        if (done_cnt != start + 1) begin
            errors++;
            $display("[TB] FAIL wrap_done got %0d pulses expected 1", done_cnt - start);
        end
        next_cycle();
        checks++;
        if (addr_q.size() != 0 || note_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL wrap_drain got %0d/%0d left expected 0/0", addr_q.size(), note_q.size());
        end
    endtask

    task automatic test_priority();
        int start;
        mem[8'h40] = 8'hC4;
        mem[8'h41] = 8'hC7;
        mem[8'h42] = 8'h23;
        mem[8'h43] = 8'hF0;
        tempo     = 4'd15;
        song_base = 8'h40;
        addr_q.push_back(8'h40);
        addr_q.push_back(8'h41);
        addr_q.push_back(8'h42);
        note_q.push_back('{freq: 7'h42, mute: 1'b0, dur: 16'd4});
        start = done_cnt;
        pulse_play();
        for (int i = 0; i < 50 && mute; i++) next_cycle();
        repeat (3) next_cycle();
        stop  = 1'b1;
        pause = 1'b1;
        play  = 1'b1;
        next_cycle();
        stop  = 1'b0;
        pause = 1'b0;
        play  = 1'b0;
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle got busy=%b rd_req=%b expected 0/0", busy, rd_req); end
        checks++; if (mute !== 1'b1) begin errors++; $display("[TB] FAIL prio_mute got %b expected 1", mute); end
        checks++; if (freq_out !== 7'h42) begin errors++; $display("[TB] FAIL prio_freq_held got %h expected 42", freq_out); end
        repeat (4) next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_stays_idle got busy=%b expected 0", busy); end
        checks++; if (done_cnt != start) begin errors++; $display("[TB] FAIL prio_no_done got %0d pulses expected 0", done_cnt - start); end
        checks++;
        if (addr_q.size() != 0 || note_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL prio_drain got %0d/%0d left expected 0/0", addr_q.size(), note_q.size());
        end
    endtask

`ifdef SONG_LOOP_EN
    task automatic test_loop();
        int start;
        mem[8'h40] = 8'h10;
        mem[8'h41] = 8'hF0;
        tempo     = 4'd15;
        song_base = 8'h40;
        addr_q.push_back(8'h40);
        addr_q.push_back(8'h41);
        addr_q.push_back(8'h40);
        addr_q.push_back(8'h41);
        addr_q.push_back(8'h40);
        note_q.push_back('{freq: 7'h01, mute: 1'b0, dur: 16'd4});
        note_q.push_back('{freq: 7'h01, mute: 1'b0, dur: 16'd4});
        start = done_cnt;
        pulse_play();
        for (int i = 0; i < 200 && done_cnt < start + 2; i++) next_cycle();
        checks++;
        if (done_cnt != start + 2) begin
            errors++;
            $display("[TB] FAIL loop_done got %0d pulses expected 2", done_cnt - start);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL loop_busy got %b expected 1", busy); end
        checks++; if (rd_addr !== 8'h40) begin errors++; $display("[TB] FAIL loop_addr got %h expected 40", rd_addr); end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL loop_stop got busy=%b expected 0", busy); end
        checks++;
        if (addr_q.size() != 0 || note_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL loop_drain got %0d/%0d left expected 0/0", addr_q.size(), note_q.size());
        end
    endtask
`endif

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog got no finish expected finish before 400000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        rst        = 1'b1;
        play       = 1'b0;
        pause      = 1'b0;
        stop       = 1'b0;
        song_base  = 8'h00;
        tempo      = 4'd15;
        rd_valid   = 1'b0;
        rd_data    = 8'h00;
        stall      = 1'b0;
        late_valid = 1'b0;
        late_data  = 8'h00;
        seen       = 1'b0;
        errors     = 0;
        checks     = 0;
        done_cnt   = 0;
        run        = 0;
        prev_req   = 1'b0;
        cap_freq   = 7'h00;
        cap_mute   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;

        test_reset();
`ifdef SONG_LOOP_EN
        test_loop();
        test_stop_fetch(7'h01);
`else
        test_note_timing();
        test_rest_tempo();
        test_pause_resume();
        test_stop_fetch(7'h07);
        test_addr_wrap();
        test_priority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_transport_ctrl.md
# song_transport_ctrl

Transport controller that sequences note playback for the tone generator. It accepts play, pause and stop commands and fetches note bytes from a note store over a request/valid handshake. It decodes the note bytes, times each note against a tempo-scaled beat tick, and drives the 7-bit `{octave, note}` frequency code plus a mute flag. It sits between the user-control logic (buttons, level input) and the note memory and frequency generator.

## Interface
- `TICK_BASE`, default 16'd50000: clock cycles per sub-tick, legal range 1 to 65535.
- `ADDR_W`, default 8: note-store address width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `play`  in  1  one-cycle command: start from IDLE, or resume from PAUSED.
- `pause`  in  1  one-cycle command, honored only in HOLD.
- `stop`  in  1  one-cycle command: abort to IDLE from any state.
- `song_base`  in  ADDR_W  first note address, latched on `play` in IDLE.
- `tempo`  in  4  sub-ticks per beat = 16 − `tempo`, so 1 to 16.
- `rd_req`  out  1  note fetch request.
- `rd_addr`  out  ADDR_W  fetch address, stable while `rd_req` is high.
- `rd_valid`  in  1  `rd_data` valid, sampled only while `rd_req` is high.
- `rd_data`  in  8  note byte.
- `freq_out`  out  7  `{octave[2:0], note[3:0]}`.
- `mute`  out  1  tone generator silenced.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at end of song.

## Operation
- States: IDLE, FETCH, DECODE, HOLD, PAUSED.
- Note byte format: `[7:4]` is the code, `[3:0]` is the argument.
  - Code 0–11: a note. Set `freq_out` = {octave, code}, `mute`=0, beats = arg+1, go to HOLD.
  - Code 14: a rest. Set `mute`=1, beats = arg+1, go to HOLD.
  - Code 12: set octave. If arg < 5, octave ← arg[2:0]; otherwise octave is unchanged. Then `rd_addr`+1 and go to FETCH.
  - Code 13: reserved, treated as a NOP. Then `rd_addr`+1 and go to FETCH.
  - Code 15: end of song. Behaviour is given under Configuration.
- IDLE:
  - On `play`: `rd_addr`←`song_base`, octave←0, go to FETCH.
  - `pause` is ignored.
  - `rd_valid` is ignored.
- FETCH: hold `rd_req`=1. On `rd_valid`, capture `rd_data`, drop `rd_req` next cycle and go to DECODE.
- HOLD:
  - On entry: beat counter ← beats, sub-tick prescaler ← 0, beat divider ← 0.
  - The prescaler wraps at `TICK_BASE`−1. Each wrap is a sub-tick.
  - The beat divider counts sub-ticks up to (16−`tempo`)−1. Each wrap is a beat, and each beat decrements the beat counter.
  - When the counter reaches 0: `rd_addr`+1, go to FETCH.
  - `tempo` is compared live, so a change takes effect from the next sub-tick.
- PAUSED:
  - Entered from HOLD on `pause`.
  - All counters are frozen and `mute`=1.
  - On `play`: return to HOLD and restore the `mute` value held before the pause.
- `rd_addr` increments wrap modulo 2^ADDR_W.
- Command priority when asserted in the same cycle: `stop` > `pause` > `play`.
- `stop` in any state:
  - Next state IDLE, `rd_req`=0, `mute`=1, `freq_out` held.
  - An outstanding fetch is abandoned. A late `rd_valid` is ignored.
- `play` outside IDLE and PAUSED is ignored.

## Timing
- Reset values:
  - `rd_req`=0, `rd_addr`=0, `freq_out`=0, `mute`=1, `busy`=0, `done`=0.
  - State IDLE, octave=0, all counters 0.
- All outputs are registered.
- `play` in IDLE → `rd_req`=1 on the next cycle.
- Fetch path: `rd_valid` sampled at edge N → `rd_req`=0 at N+1 (DECODE) → `freq_out`/`mute` updated at N+2 (entry to HOLD).
  - An octave byte costs 2 cycles from `rd_valid` to the next `rd_req`.
- Note duration in HOLD is exactly beats × (16−`tempo`) × `TICK_BASE` cycles at constant tempo. This excludes time spent in PAUSED.
- Zero-wait memory (`rd_valid` in the same cycle as `rd_req`): a note-to-note gap of 3 cycles from HOLD exit to the next HOLD entry.
- `done` asserts for one cycle, coincident with entry to IDLE.
- Async `rst` mid-fetch: `rd_req` drops immediately.

## Configuration
- `SONG_LOOP_EN` defined: code 15 sets `rd_addr`←latched `song_base` and goes to FETCH. Octave is kept. `done` pulses once per loop, with `busy` staying high.
- `SONG_LOOP_EN` not defined: code 15 pulses `done`, sets `mute`=1 and goes to IDLE.

## Test plan
Common setup: `TICK_BASE`=4, memory with 1-cycle `rd_valid` latency.
- Note timing: memory [0]=0xC3, [1]=0x52, [2]=0xF0; `tempo`=15; `play` with base 0 → `freq_out`=0x35, `mute`=0 for 12 cycles, then `done` pulse and IDLE.
- Rest and tempo: byte 0xE1, `tempo`=14 → `mute`=1 for 2×2×4 = 16 cycles.
- Pause/resume: `pause` 5 cycles into a 16-cycle note, 20 cycles idle, then `play` → the note ends 16 + 20 + 1 cycles after it started, with `mute` restored to 0.
- Stop mid-fetch: memory stalls `rd_valid`; `stop` → `rd_req`=0 next cycle; a late `rd_valid` causes no state change; `busy`=0.
- Loop build: with `SONG_LOOP_EN`, sequence 0x10, 0xF0 with base 0x40 → `rd_addr` returns to 0x40 and `done` pulses each pass. Address wrap: base 0xFF, a note at 0xFF → next fetch at 0x00.
- Priority and ignores: `stop`+`pause`+`play` in one HOLD cycle → IDLE; octave byte 0xC7 → octave unchanged.
